orb_win_ctrl: RTL

- Raster scheduler for the row delay-line chain in the ORB patch extractor.
- Counts incoming pixels column by column and row by row.
- Drives the shared enable of every row delay line.
- Reports when a full WIN x WIN window is resident and gives the window-centre coordinate to downstream descriptor logic.
- Also reports frame completion.

---
 rtl/orb_win_pkg.sv | 24 ++
 rtl/orb_win_ctrl_cnt.sv | 57 +++++
 rtl/orb_win_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/orb_win_pkg.sv
// orb_win_pkg: shared defaults, FSM encoding and half-window helper for the
// ORB window controller.
package orb_win_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int WIN_DEF   = 31;

  // Distance from a window edge to its centre for the default window.
  localparam int HW = (WIN_DEF - 1) / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Half-window for an arbitrary (odd) window side.
  function automatic int half_win(input int win);
    return (win - 1) / 2;
  endfunction

endpackage

// File: rtl/orb_win_ctrl_cnt.sv
// orb_raster_cnt: column/row raster counter pair. The registers hold the
// coordinate of the next expected pixel; i_clr forces the pixel being
// accepted to (0,0) so a start-of-frame pixel restarts the raster.
import orb_win_pkg::*;

module orb_raster_cnt #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CB    = 10,
  parameter int RB    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CB-1:0] o_col,
  output logic [RB-1:0] o_row,
  output logic          o_col_wrap,
  output logic          o_last
);

  logic [CB-1:0] r_col;
  logic [RB-1:0] r_row;
  logic [CB-1:0] w_pix_col;
  logic [RB-1:0] w_pix_row;

  // Coordinate of the pixel presented this cycle and its wrap flags.
  always_comb begin
    w_pix_col  = i_clr ? {CB{1'b0}} : r_col;
    w_pix_row  = i_clr ? {RB{1'b0}} : r_row;
    o_col_wrap = (w_pix_col == CB'(IMG_W - 1));
    o_last     = o_col_wrap && (w_pix_row == RB'(IMG_H - 1));
  end

  // Advance past the accepted pixel, wrapping at row and frame ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= {CB{1'b0}};
      r_row <= {RB{1'b0}};
    end else if (i_inc) begin
      if (o_col_wrap) begin
        r_col <= {CB{1'b0}};
        r_row <= o_last ? {RB{1'b0}} : (w_pix_row + RB'(1));
      end else begin
        r_col <= w_pix_col + CB'(1);
        r_row <= w_pix_row;
      end
    end else begin
      r_col <= r_col;
      r_row <= r_row;
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/orb_win_ctrl.sv
// orb_win_ctrl: raster scheduler for the ORB row delay-line chain.
// Optional sticky protocol error output enabled by ORB_WIN_CTRL_ERR_EN.
import orb_win_pkg::*;

module orb_win_ctrl #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int WIN   = WIN_DEF,
  parameter int CB    = 10,
  parameter int RB    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_vld,
  input  logic          sof,
  output logic          line_ena,
  output logic          win_vld,
  output logic [CB-1:0] ctr_col,
  output logic [RB-1:0] ctr_row,
  output logic          frame_done,
  output logic          busy
`ifdef ORB_WIN_CTRL_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int L_HW = half_win(WIN);

  state_t        r_state;
  state_t        w_nxt;
  logic          w_acc;
  logic          w_win;
  logic [CB-1:0] w_cnt_col;
  logic [RB-1:0] w_cnt_row;
  logic [CB-1:0] w_pix_col;
  logic [RB-1:0] w_pix_row;
  logic          w_col_wrap;
  logic          w_last;
  logic          r_win_vld;
  logic [CB-1:0] r_ctr_col;
  logic [RB-1:0] r_ctr_row;
  logic          r_frame_done;
  logic          r_busy;

  orb_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CB    (CB),
    .RB    (RB)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_acc),
    .i_clr      (sof),
    .o_col      (w_cnt_col),
    .o_row      (w_cnt_row),
    .o_col_wrap (w_col_wrap),
    .o_last     (w_last)
  );

  // Pixel acceptance, its coordinate and whether it completes a window.
  always_comb begin
    w_acc     = pix_vld & (sof | (r_state == ST_FILL) | (r_state == ST_RUN));
    w_pix_col = sof ? {CB{1'b0}} : w_cnt_col;
    w_pix_row = sof ? {RB{1'b0}} : w_cnt_row;
    w_win     = w_acc && (w_pix_col >= CB'(WIN - 1)) && (w_pix_row >= RB'(WIN - 1));
  end

  // Next-state: a start-of-frame pixel always restarts into FILL.
  always_comb begin
    w_nxt = r_state;
    if (w_acc) begin
      if (w_last) begin
        w_nxt = ST_DONE;
      end else if (w_col_wrap && (w_pix_row == RB'(WIN - 2))) begin
        w_nxt = ST_RUN;
      end else if (sof) begin
        w_nxt = ST_FILL;
      end else begin
        w_nxt = r_state;
      end
    end else if (r_state == ST_DONE) begin
      w_nxt = ST_IDLE;
    end else begin
      w_nxt = r_state;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Registered window, frame-done and busy outputs; centre holds between windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_vld    <= 1'b0;
      r_ctr_col    <= {CB{1'b0}};
      r_ctr_row    <= {RB{1'b0}};
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_win_vld    <= w_win;
      r_frame_done <= (w_nxt == ST_DONE);
      r_busy       <= (w_nxt != ST_IDLE);
      if (w_win) begin
        r_ctr_col <= w_pix_col - CB'(L_HW);
        r_ctr_row <= w_pix_row - RB'(L_HW);
      end else begin
        r_ctr_col <= r_ctr_col;
        r_ctr_row <= r_ctr_row;
      end
    end
  end

  assign line_ena   = w_acc;
  assign win_vld    = r_win_vld;
  assign ctr_col    = r_ctr_col;
  assign ctr_row    = r_ctr_row;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

`ifdef ORB_WIN_CTRL_ERR_EN
  logic r_err;
  logic r_done_seen;
  logic w_err_set;

  // Protocol violations: resync mid-frame, or stray pixels after a completed frame.
  always_comb begin
    w_err_set = (pix_vld & sof & ((r_state == ST_FILL) | (r_state == ST_RUN)) &
                 ((w_cnt_col != {CB{1'b0}}) | (w_cnt_row != {RB{1'b0}}))) |
                (pix_vld & ~sof & (r_state == ST_IDLE) & r_done_seen);
  end

  // Sticky error flag and record of a completed frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      r_err       <= r_err | w_err_set;
      r_done_seen <= r_done_seen | (w_nxt == ST_DONE);
    end
  end

  assign err = r_err;
`endif

endmodule
